// File: rtl/sobel_calc_if.sv
// Window-in / result-out handshake bundle for the Sobel edge pipeline.
// The producer/consumer side uses master; the calculator uses slave.
interface sobel_calc_if;
  logic       window_valid;
  logic [7:0] window [0:8];
  logic       window_ready;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result_data;

  modport master (
    output window_valid, window, result_ready,
    input  window_ready, result_valid, result_data
  );

  modport slave (
    input  window_valid, window, result_ready,
    output window_ready, result_valid, result_data
  );
endinterface

// File: rtl/sobel_calc.sv
// Three-stage Sobel gradient pipeline: column/row tap sums, absolute gradients, magnitude.
// The whole pipeline freezes while a finished result waits on the consumer.
module sobel_calc #(
  parameter int         BINARY    = 0,
  parameter logic [7:0] THRESHOLD = 8'd100
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  sobel_calc_if.slave bus,
  output logic        busy,
  output logic [15:0] pixel_count,
  output logic [15:0] edge_count
);

  logic        stall;
  logic        xfer;
  logic        s1_valid, s2_valid, s3_valid;
  logic [9:0]  xp_d, xn_d, yp_d, yn_d;
  logic [9:0]  xp_q, xn_q, yp_q, yn_q;
  logic [10:0] gx, gy;
  logic [9:0]  abs_gx, abs_gy;
  logic [9:0]  ax_q, ay_q;
  logic [10:0] mag;
  logic        edge_d, edge_q;
  logic [7:0]  res_d, res_q;

  function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] m,
                                         input logic [7:0] b);
    return {2'b00, a} + {1'b0, m, 1'b0} + {2'b00, b};
  endfunction

  assign stall            = s3_valid && !bus.result_ready;
  assign xfer             = s3_valid && bus.result_ready;
  assign bus.window_ready = !stall;
  assign bus.result_valid = s3_valid;
  assign bus.result_data  = res_q;
  assign busy             = s1_valid || s2_valid || s3_valid;

  // Positive/negative halves of the 3x3 Sobel kernels
  always_comb begin
    xp_d = tap_sum(bus.window[2], bus.window[5], bus.window[8]);
    xn_d = tap_sum(bus.window[0], bus.window[3], bus.window[6]);
    yp_d = tap_sum(bus.window[6], bus.window[7], bus.window[8]);
    yn_d = tap_sum(bus.window[0], bus.window[1], bus.window[2]);
  end

  always_comb begin
    gx     = {1'b0, xp_q} - {1'b0, xn_q};
    gy     = {1'b0, yp_q} - {1'b0, yn_q};
    abs_gx = gx[10] ? 10'(-gx) : gx[9:0];
    abs_gy = gy[10] ? 10'(-gy) : gy[9:0];
  end

  always_comb begin
    mag    = {1'b0, ax_q} + {1'b0, ay_q};
    edge_d = (mag >= {3'b000, THRESHOLD});
    res_d  = 8'h00;
    if (BINARY != 0) begin
      res_d = edge_d ? 8'hFF : 8'h00;
    end else begin
      res_d = (mag > 11'd255) ? 8'hFF : mag[7:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      xp_q     <= '0;
      xn_q     <= '0;
      yp_q     <= '0;
      yn_q     <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      res_q    <= '0;
      edge_q   <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      res_q    <= '0;
      edge_q   <= 1'b0;
    end else if (!stall) begin
      // window_ready == !stall here, so a valid window is always accepted
      s1_valid <= bus.window_valid;
      xp_q     <= xp_d;
      xn_q     <= xn_d;
      yp_q     <= yp_d;
      yn_q     <= yn_d;
      s2_valid <= s1_valid;
      ax_q     <= abs_gx;
      ay_q     <= abs_gy;
      s3_valid <= s2_valid;
      res_q    <= res_d;
      edge_q   <= edge_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pixel_count <= '0;
      edge_count  <= '0;
    end else if (clear) begin
      pixel_count <= '0;
      edge_count  <= '0;
    end else if (xfer) begin
      if (pixel_count != 16'hFFFF) pixel_count <= pixel_count + 16'd1;
      if (edge_q && (edge_count != 16'hFFFF)) edge_count <= edge_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sobel_calc.sv
// Randomized bench for sobel_calc: a kernel-convolution reference model feeds a
// scoreboard checked on every transfer; magnitude and binary variants run in lockstep.
module tb_sobel_calc;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear = 1'b0;
  logic        busy_m, busy_b;
  logic [15:0] pix_m, edge_m, pix_b, edge_b;

  always #5 clk = ~clk;

  sobel_calc_if bus_mag ();
  sobel_calc_if bus_bin ();

  sobel_calc #(.BINARY(0), .THRESHOLD(8'd100)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus_mag.slave),
    .busy(busy_m), .pixel_count(pix_m), .edge_count(edge_m)
  );

  sobel_calc #(.BINARY(1), .THRESHOLD(8'd100)) dut_bin (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus_bin.slave),
    .busy(busy_b), .pixel_count(pix_b), .edge_count(edge_b)
  );

  typedef struct packed {
    logic [7:0] mag_data;
    logic [7:0] bin_data;
    logic       edge_flag;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_pix = '0;
  logic [15:0] m_edge = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_m, prev_b;
  logic [7:0]  w_mon [0:8];
  logic [7:0]  w_idle [0:8];
  logic [7:0]  w_flat [0:8];
  logic [7:0]  w_col [0:8];
  logic [7:0]  w_mid [0:8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: direct 3x3 convolution with the Sobel kernels
  function automatic exp_t sobel_ref(input logic [7:0] w [0:8]);
    int   kx [0:8];
    int   ky [0:8];
    int   gx, gy, mag;
    exp_t r;
    kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * int'(w[i]);
      gy += ky[i] * int'(w[i]);
    end
    mag         = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    r.mag_data  = (mag > 255) ? 8'd255 : 8'(mag);
    r.edge_flag = (mag >= 100);
    r.bin_data  = r.edge_flag ? 8'hFF : 8'h00;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      check("rst_result_valid", bus_mag.result_valid, 1'b0);
      check("rst_window_ready", bus_mag.window_ready, 1'b1);
      check("rst_busy", busy_m, 1'b0);
      check("rst_pixel_count", pix_m, 16'd0);
      check("rst_edge_count", edge_m, 16'd0);
      check("rst_data", bus_mag.result_data, 8'd0);
      exp_q.delete();
      m_pix = '0;
      m_edge = '0;
      prev_stall = 1'b0;
    end else begin
      check("window_ready", bus_mag.window_ready,
            !(bus_mag.result_valid && !bus_mag.result_ready));
      check("busy", busy_m, exp_q.size() != 0);
      check("busy_bin", busy_b, exp_q.size() != 0);
      check("pixel_count", pix_m, m_pix);
      check("edge_count", edge_m, m_edge);
      check("pixel_count_bin", pix_b, m_pix);
      check("edge_count_bin", edge_b, m_edge);
      if (prev_stall) begin
        check("hold_valid", bus_mag.result_valid, 1'b1);
        check("hold_data", bus_mag.result_data, prev_m);
        check("hold_data_bin", bus_bin.result_data, prev_b);
      end
      if (clear) begin
        exp_q.delete();
        m_pix = '0;
        m_edge = '0;
      end else begin
        if (bus_mag.result_valid && bus_mag.result_ready) begin
          check("result_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result_data", bus_mag.result_data, e.mag_data);
            check("result_valid_bin", bus_bin.result_valid, 1'b1);
            check("result_data_bin", bus_bin.result_data, e.bin_data);
            if (m_pix != 16'hFFFF) m_pix = m_pix + 16'd1;
            if (e.edge_flag && m_edge != 16'hFFFF) m_edge = m_edge + 16'd1;
          end
        end
        if (bus_mag.window_valid && bus_mag.window_ready) begin
          w_mon = bus_mag.window;
          exp_q.push_back(sobel_ref(w_mon));
        end
      end
      prev_stall = bus_mag.result_valid && !bus_mag.result_ready && !clear;
      prev_m = bus_mag.result_data;
      prev_b = bus_bin.result_data;
    end
  end

  task automatic drive(input logic v, input logic [7:0] w [0:8], input logic rr);
    bus_mag.window_valid = v;
    bus_mag.window       = w;
    bus_mag.result_ready = rr;
    bus_bin.window_valid = v;
    bus_bin.window       = w;
    bus_bin.result_ready = rr;
  endtask

  task automatic rand_window(output logic [7:0] w [0:8]);
    int base;
    base = $urandom_range(0, 200);
    if ($urandom_range(0, 1) == 0) begin
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    end else begin
      for (int i = 0; i < 9; i++) w[i] = 8'(base + $urandom_range(0, 30));
    end
  endtask

  // Called and returns at posedge+1
  task automatic stream(input int n, input int vld_pct, input int rdy_pct,
                        input int stall_at, input int stall_len);
    logic [7:0] w [0:8];
    int   sent, cyc, budget;
    logic v, rr, acc;
    sent = 0;
    cyc = 0;
    budget = n * 8 + 200;
    rand_window(w);
    while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
      v  = (sent < n) && ($urandom_range(1, 100) <= vld_pct);
      rr = ($urandom_range(1, 100) <= rdy_pct);
      if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) rr = 1'b0;
      drive(v, w, rr);
      @(negedge clk);
      acc = v && bus_mag.window_ready;
      if (stall_len > 0 && cyc == stall_at)
        check("stall_ready_drop", bus_mag.window_ready, 1'b0);
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        rand_window(w);
      end
      cyc++;
    end
    check("stream_done_in_budget", cyc < budget, 1'b1);
    drive(1'b0, w_idle, 1'b1);
  endtask

  // One window into an empty pipeline; result must appear exactly 3 cycles after accept
  task automatic run_one(input string tag, input logic [7:0] w [0:8],
                         input logic [7:0] want_m, input logic [7:0] want_b);
    drive(1'b1, w, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, w_idle, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check({tag, "_latency"}, bus_mag.result_valid, k == 3);
    end
    check({tag, "_data"}, bus_mag.result_data, want_m);
    check({tag, "_data_bin"}, bus_bin.result_data, want_b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    w_idle = '{default: 8'd0};
    w_flat = '{default: 8'd50};
    w_col  = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
    w_mid  = '{8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30};
    drive(1'b0, w_idle, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    run_one("flat", w_flat, 8'd0, 8'h00);
    check("flat_pixel_count", pix_m, 16'd1);
    check("flat_edge_count", edge_m, 16'd0);
    run_one("column", w_col, 8'd255, 8'hFF);
    check("column_edge_count", edge_m, 16'd1);
    run_one("mid", w_mid, 8'd80, 8'h00);
    check("mid_edge_count", edge_m, 16'd1);

    pulse_clear();
    stream(6, 100, 100, 4, 5);
    check("stall_pixel_count", pix_m, 16'd6);

    stream(300, 100, 100, 0, 0);
    stream(300, 60, 50, 0, 0);
    stream(300, 90, 20, 0, 0);
    stream(300, 30, 90, 0, 0);

    // Clear with two windows in flight, and a third offered in the clear cycle
    drive(1'b1, w_col, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, w_mid, 1'b1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    drive(1'b1, w_flat, 1'b1);
    @(posedge clk);
    #1;
    clear = 1'b0;
    drive(1'b0, w_idle, 1'b1);
    @(negedge clk);
    check("clear_busy", busy_m, 1'b0);
    check("clear_result_valid", bus_mag.result_valid, 1'b0);
    check("clear_pixel_count", pix_m, 16'd0);
    check("clear_edge_count", edge_m, 16'd0);
    @(posedge clk);
    #1;
    run_one("after_clear", w_col, 8'd255, 8'hFF);

    stream(40, 100, 100, 0, 0);
    drive(1'b1, w_col, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, w_mid, 1'b1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    drive(1'b0, w_idle, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("reset_busy", busy_m, 1'b0);
    check("reset_result_valid", bus_mag.result_valid, 1'b0);
    check("reset_pixel_count", pix_m, 16'd0);
    @(posedge clk);
    #1;
    run_one("after_reset", w_mid, 8'd80, 8'h00);

    pulse_clear();
    stream(65540, 100, 100, 0, 0);
    check("pixel_count_saturated", pix_m, 16'hFFFF);
    run_one("after_saturation", w_flat, 8'd0, 8'h00);
    check("pixel_count_still_saturated", pix_m, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_calc.md
SOBEL_CALC -- requirements
Module: sobel_calc

Interface
REQ-001 SHALL have parameter BINARY, default 0, meaning 0 = output saturated magnitude, 1 = output thresholded edge map.
REQ-002 SHALL have parameter THRESHOLD, default 8'd100, meaning the edge threshold applied to the magnitude.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of the pipeline and counters.
REQ-006 SHALL have port window_valid  input  1  window holds a complete 3x3 neighbourhood.
REQ-007 SHALL have port window  input  8 x [0:8]  pixels, row-major: 0 = top-left, 4 = centre, 8 = bottom-right.
REQ-008 SHALL have port window_ready  output  1  block can accept a window this cycle.
REQ-009 SHALL have port result_valid  output  1  result_data holds a valid output pixel.
REQ-010 SHALL have port result_ready  input  1  consumer takes result_data this cycle.
REQ-011 SHALL have port result_data  output  8  output edge pixel.
REQ-012 SHALL have port busy  output  1  at least one pipeline stage holds valid data.
REQ-013 SHALL have port pixel_count  output  16  number of results transferred.
REQ-014 SHALL have port edge_count  output  16  number of transferred results with magnitude >= THRESHOLD.

Function
REQ-015 SHALL accept a window on a cycle when window_valid && window_ready are both high.
REQ-016 SHALL transfer a result on a cycle when result_valid && result_ready are both high.
REQ-017 SHALL define stall = result_valid && !result_ready, and window_ready SHALL equal !stall (combinational).
REQ-018 SHALL hold every stage register and its valid bit unchanged during stall; bubbles are not collapsed.
REQ-019 SHALL keep result_data stable while result_valid is high and result_ready is low.
REQ-020 Stage 1 SHALL register four unsigned 10-bit sums and a valid bit:
- Xp = w2 + 2*w5 + w8
- Xn = w0 + 2*w3 + w6
- Yp = w6 + 2*w7 + w8
- Yn = w0 + 2*w1 + w2
REQ-021 Stage 2 SHALL compute signed 11-bit Gx = Xp - Xn and Gy = Yp - Yn, and SHALL register |Gx| and |Gy| (10-bit, range 0..1020) with a valid bit.
REQ-022 Stage 3 SHALL compute the 11-bit mag = |Gx| + |Gy| (range 0..2040).
REQ-023 Stage 3 SHALL register result_data = min(mag, 255) when BINARY = 0.
REQ-024 Stage 3 SHALL register result_data = 8'hFF if mag >= THRESHOLD, else 8'h00, when BINARY = 1.
REQ-025 Stage 3 SHALL register one edge flag (mag >= THRESHOLD) alongside result_data.
REQ-026 Latency SHALL be exactly 3 cycles from accept to result_valid when there is no stall; with continuous valid and ready, throughput SHALL be one result per cycle.
REQ-027 Results SHALL leave the block in acceptance order; no window is dropped or duplicated under any result_ready pattern.
REQ-028 pixel_count SHALL increment by 1 on each transfer and SHALL saturate at 16'hFFFF.
REQ-029 edge_count SHALL increment by 1 on each transfer whose edge flag is set and SHALL saturate at 16'hFFFF.
REQ-030 When clear is high at a rising edge, the block SHALL zero all valid bits, result_data, pixel_count and edge_count.
REQ-031 clear SHALL take priority over a simultaneous accept or transfer; neither the accepted window nor the transferred result is counted.
REQ-032 busy SHALL be the OR of the three stage valid bits.

Reset
REQ-033 While n_rst is low, all stage registers, all valid bits, result_data, pixel_count and edge_count SHALL be 0, independent of clk.
REQ-034 While n_rst is low, window_ready SHALL be 1 and result_valid and busy SHALL be 0.
REQ-035 Reset asserted mid-stream SHALL discard all in-flight windows; the first result after reset release SHALL come from the first window accepted after release.

Verification
REQ-036 Flat window, all pixels 50, result_ready = 1 -> result_valid 3 cycles after accept; result_data = 0; pixel_count = 1; edge_count = 0.
REQ-037 Left column 0, right column 255, middle column 0 -> Gx = 1020, Gy = 0; result_data = 255; edge_count = 1.
REQ-038 Left column 10, right column 30 -> mag = 80; result_data = 80 with BINARY = 0; result_data = 0 with BINARY = 1 and THRESHOLD = 100.
REQ-039 Stream 6 distinct windows with result_ready low for 5 cycles mid-stream -> window_ready falls in the first stall cycle; held result_data stays stable; all 6 results arrive in order; pixel_count = 6.
REQ-040 Assert clear or n_rst with 2 windows in flight -> next cycle busy = 0, result_valid = 0, both counters = 0; a fresh window then yields a correct result after 3 cycles.
REQ-041 Preload pixel_count = 16'hFFFF via a long run (or force), then transfer one more result -> pixel_count stays 16'hFFFF.
